serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl.sv | 108 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full_sub cell is stepped LSB first over WIDTH
// clocks to form a - b - bin_init. A start/busy/done handshake wraps it.

module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// state | meaning
// IDLE  | waiting for start; operands are captured on the accepting edge
// RUN   | one bit per clock through full_sub, LSB first
// DONE  | single-cycle done pulse, result registers just loaded
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             fs_d;
  logic             fs_bout;

  full_sub u_full_sub (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Sequencer and datapath registers; the result is loaded on the same edge
  // that enters DONE so it is valid alongside the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin_init;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fs_d, res_sh[WIDTH-1:1]};
          brw    <= fs_bout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            diff       <= {fs_d, res_sh[WIDTH-1:1]};
            borrow_out <= fs_bout;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin_init = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int n_chk = 0;
  int n_fail = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .bin_init   (bin_init),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_borrow;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: unsigned subtraction in plain integer arithmetic.
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
    int r;
    r = int'(x) - int'(y) - int'(bi);
    ref_sub = {r < 0, 8'(r & 255)};
  endfunction

  // Waits for done after an accept edge; n = edges elapsed since accept.
  task automatic wait_done(output int n, output bit got);
    n = 0;
    got = 0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
  endtask

  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin, input string nm);
    int n;
    bit got;
    logic [8:0] exp;
    exp = ref_sub(ta, tb_v, tbin);
    @(negedge clk);
    a = ta; b = tb_v; bin_init = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy_rise"}, 32'(busy), 32'd1);
    wait_done(n, got);
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(n), 32'(WIDTH));
    chk({nm, "_diff"}, 32'(diff), 32'(exp[7:0]));
    chk({nm, "_borrow"}, 32'(borrow_out), 32'(exp[8]));
    chk({nm, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    bit got;
    int cnt_done;
    int last_done;
    logic [8:0] exp;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tbl_diff", i), 32'(diff), 32'(vecs[i].exp_diff));
      chk($sformatf("vec%0d_tbl_borrow", i), 32'(borrow_out), 32'(vecs[i].exp_borrow));
    end

    // start pulsed again mid-run, operands changed: ignored
    @(negedge clk);
    a = 8'h80; b = 8'h01; bin_init = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'hFF; bin_init = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'h55; b = 8'hAA;
    n = 4;
    got = 0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
    end
    chk("midstart_done_seen", 32'(got), 32'd1);
    chk("midstart_latency", 32'(n), 32'(WIDTH));
    chk("midstart_diff", 32'(diff), 32'h7F);
    chk("midstart_borrow", 32'(borrow_out), 32'd0);
    cnt_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) cnt_done++;
    end
    chk("midstart_no_second_op", 32'(cnt_done), 32'd0);

    // Asynchronous reset in RUN cycle 4; diff currently holds 0x7F
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin_init = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cnt_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done) cnt_done++;
    end
    chk("arst_no_done", 32'(cnt_done), 32'd0);
    do_op(8'h09, 8'h04, 1'b0, "post_rst");
    chk("post_rst_diff_05", 32'(diff), 32'h05);

    // start held high: one op per WIDTH+2 cycles
    @(negedge clk);
    a = 8'h03; b = 8'h01; bin_init = 1'b0; start = 1'b1;
    cnt_done = 0;
    last_done = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt_done++;
        chk("held_diff", 32'(diff), 32'h02);
        chk("held_borrow", 32'(borrow_out), 32'd0);
        if (last_done >= 0) chk("held_period", 32'(i - last_done), 32'(WIDTH + 2));
        last_done = i;
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(cnt_done), 32'd3);
    repeat (3) @(posedge clk);

    // Randomized against reference model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbi;
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      exp = ref_sub(ra, rb, rbi);
      do_op(ra, rb, rbi, "rand");
      chk("rand_model_diff", 32'(diff), 32'(exp[7:0]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
